// File: rtl/ctrl_pkg.sv
// Opcode, ALU and forward-select encodings plus the control bundle
// carried through the D->E stage of the 5-stage pipeline.
package ctrl_pkg;

  // Bundle field widths track the default RAW/ALUFW of pipe_ctrl_unit.
  localparam int unsigned CTRL_RAW   = 3;
  localparam int unsigned CTRL_ALUFW = 2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic                  regwrite;
    logic                  memwrite;
    logic                  memtoreg;
    logic                  imm;
    logic                  branch;
    logic                  jmp;
    logic                  mul;
    logic [CTRL_ALUFW-1:0] alufunc;
    logic [CTRL_RAW-1:0]   rd;
    logic [CTRL_RAW-1:0]   rs;
    logic [CTRL_RAW-1:0]   rt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_opcode_decoder.sv
// Combinational D-stage decode: opcode and register fields to control bundle,
// plus which source registers the instruction actually reads.
module pipe_opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW   = 4,
  parameter int unsigned ALUFW = 2
) (
  input  logic [OPW-1:0]      opcode_i,
  input  logic [CTRL_RAW-1:0] rd_i,
  input  logic [CTRL_RAW-1:0] rs_i,
  input  logic [CTRL_RAW-1:0] rt_i,
  output ctrl_t               ctrl_o,
  output logic                use_rs_o,
  output logic                use_rt_o
);

  logic [ALUFW-1:0] alu;
  logic             wr;

  always_comb begin
    ctrl_o   = CTRL_BUBBLE;
    alu      = ALUFW'(ALU_ADD);
    wr       = 1'b0;
    use_rs_o = 1'b0;
    use_rt_o = 1'b0;
    case (opcode_i)
      OPW'(OP_NOP): ;
      OPW'(OP_ADD): begin
        wr = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_SUB): begin
        alu = ALUFW'(ALU_SUB); wr = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_AND): begin
        alu = ALUFW'(ALU_AND); wr = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_OR): begin
        alu = ALUFW'(ALU_OR); wr = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_ADDI): begin
        ctrl_o.imm = 1'b1; wr = 1'b1; use_rs_o = 1'b1;
      end
      OPW'(OP_LD): begin
        ctrl_o.imm = 1'b1; ctrl_o.memtoreg = 1'b1; wr = 1'b1; use_rs_o = 1'b1;
      end
      OPW'(OP_ST): begin
        ctrl_o.imm = 1'b1; ctrl_o.memwrite = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_BEQ): begin
        alu = ALUFW'(ALU_SUB); ctrl_o.branch = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      OPW'(OP_JMP): begin
        ctrl_o.branch = 1'b1; ctrl_o.jmp = 1'b1;
      end
      OPW'(OP_MUL): begin
        ctrl_o.mul = 1'b1; wr = 1'b1; use_rs_o = 1'b1; use_rt_o = 1'b1;
      end
      default: ;
    endcase
    ctrl_o.alufunc  = CTRL_ALUFW'(alu);
    // r0 is hardwired zero, so writes to it are dropped at decode.
    ctrl_o.regwrite = wr & (rd_i != '0);
    ctrl_o.rd       = rd_i;
    ctrl_o.rs       = rs_i;
    ctrl_o.rt       = rt_i;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decode, D->E/E->M/M->W control registers, load-use and
// multi-cycle MUL interlocks, E-stage branch redirect and operand forwarding.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned RAW     = 3,
  parameter int unsigned ALUFW   = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid_d,
  input  logic [OPW-1:0]   i_opcode_d,
  input  logic [RAW-1:0]   i_rs_d,
  input  logic [RAW-1:0]   i_rt_d,
  input  logic [RAW-1:0]   i_rd_d,
  input  logic             i_zero_e,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_d,
  output logic             o_redirect_e,
  output logic [ALUFW-1:0] o_alufunc_e,
  output logic             o_imm_e,
  output logic [1:0]       o_fwd_a_e,
  output logic [1:0]       o_fwd_b_e,
  output logic             o_memwrite_m,
  output logic             o_memtoreg_w,
  output logic             o_regwrite_w,
  output logic [RAW-1:0]   o_rd_w
);

  localparam int unsigned     CNTW     = ($clog2(MUL_LAT) < 2) ? 2 : $clog2(MUL_LAT);
  localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LAT - 1);

  ctrl_t           dec_ctrl, d_ctrl, e_d, e_q;
  logic            dec_use_rs, dec_use_rt, d_use_rs, d_use_rt;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            m_regwrite_d, m_regwrite_q, m_memwrite_d, m_memwrite_q;
  logic            m_memtoreg_d, m_memtoreg_q;
  logic [RAW-1:0]  m_rd_d, m_rd_q;
  logic            w_regwrite_q, w_memtoreg_q;
  logic [RAW-1:0]  w_rd_q, e_rs, e_rt;
  logic            redirect, mul_busy, load_use;

  pipe_opcode_decoder #(
    .OPW   (OPW),
    .ALUFW (ALUFW)
  ) u_decoder (
    .opcode_i (i_opcode_d),
    .rd_i     (CTRL_RAW'(i_rd_d)),
    .rs_i     (CTRL_RAW'(i_rs_d)),
    .rt_i     (CTRL_RAW'(i_rt_d)),
    .ctrl_o   (dec_ctrl),
    .use_rs_o (dec_use_rs),
    .use_rt_o (dec_use_rt)
  );

  always_comb begin
    d_ctrl   = CTRL_BUBBLE;
    d_use_rs = 1'b0;
    d_use_rt = 1'b0;
    if (i_valid_d) begin
      d_ctrl   = dec_ctrl;
      d_use_rs = dec_use_rs;
      d_use_rt = dec_use_rt;
    end
  end

  assign redirect = e_q.branch & (e_q.jmp | i_zero_e);
  assign mul_busy = e_q.mul & (cnt_q != '0);
  assign load_use = e_q.memtoreg & (e_q.rd != '0) &
                    ((d_use_rs & (d_ctrl.rs == e_q.rd)) |
                     (d_use_rt & (d_ctrl.rt == e_q.rd)));

  always_comb begin
    e_d          = d_ctrl;
    cnt_d        = d_ctrl.mul ? MUL_LOAD : '0;
    m_regwrite_d = e_q.regwrite;
    m_memwrite_d = e_q.memwrite;
    m_memtoreg_d = e_q.memtoreg;
    m_rd_d       = RAW'(e_q.rd);
    // A busy MUL holds E and feeds bubbles downstream; redirect and
    // load-use both replace the incoming D instruction with a bubble.
    if (mul_busy) begin
      e_d          = e_q;
      cnt_d        = cnt_q - CNTW'(1);
      m_regwrite_d = 1'b0;
      m_memwrite_d = 1'b0;
      m_memtoreg_d = 1'b0;
      m_rd_d       = '0;
    end else if (redirect | load_use) begin
      e_d   = CTRL_BUBBLE;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= CTRL_BUBBLE;
      cnt_q        <= '0;
      m_regwrite_q <= 1'b0;
      m_memwrite_q <= 1'b0;
      m_memtoreg_q <= 1'b0;
      m_rd_q       <= '0;
      w_regwrite_q <= 1'b0;
      w_memtoreg_q <= 1'b0;
      w_rd_q       <= '0;
    end else begin
      e_q          <= e_d;
      cnt_q        <= cnt_d;
      m_regwrite_q <= m_regwrite_d;
      m_memwrite_q <= m_memwrite_d;
      m_memtoreg_q <= m_memtoreg_d;
      m_rd_q       <= m_rd_d;
      w_regwrite_q <= m_regwrite_q;
      w_memtoreg_q <= m_memtoreg_q;
      w_rd_q       <= m_rd_q;
    end
  end

  assign e_rs = RAW'(e_q.rs);
  assign e_rt = RAW'(e_q.rt);

  always_comb begin
    o_fwd_a_e = FWD_RF;
    o_fwd_b_e = FWD_RF;
    if (m_regwrite_q && m_rd_q != '0 && m_rd_q == e_rs)      o_fwd_a_e = FWD_M;
    else if (w_regwrite_q && w_rd_q != '0 && w_rd_q == e_rs) o_fwd_a_e = FWD_W;
    if (m_regwrite_q && m_rd_q != '0 && m_rd_q == e_rt)      o_fwd_b_e = FWD_M;
    else if (w_regwrite_q && w_rd_q != '0 && w_rd_q == e_rt) o_fwd_b_e = FWD_W;
  end

  assign o_stall_f    = mul_busy | (load_use & ~redirect);
  assign o_stall_d    = mul_busy | (load_use & ~redirect);
  assign o_flush_d    = redirect;
  assign o_redirect_e = redirect;
  assign o_alufunc_e  = ALUFW'(e_q.alufunc);
  assign o_imm_e      = e_q.imm;
  assign o_memwrite_m = m_memwrite_q;
  assign o_memtoreg_w = w_memtoreg_q;
  assign o_regwrite_w = w_regwrite_q;
  assign o_rd_w       = w_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model compared every
// cycle, directed hazard scenarios with literal expectations, then random traffic.
module tb_pipe_ctrl_unit;

  localparam int OPW     = 4;
  localparam int RAW     = 3;
  localparam int ALUFW   = 2;
  localparam int MUL_LAT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid_d;
  logic [OPW-1:0]   i_opcode_d;
  logic [RAW-1:0]   i_rs_d, i_rt_d, i_rd_d;
  logic             i_zero_e;
  logic             o_stall_f, o_stall_d, o_flush_d, o_redirect_e;
  logic [ALUFW-1:0] o_alufunc_e;
  logic             o_imm_e;
  logic [1:0]       o_fwd_a_e, o_fwd_b_e;
  logic             o_memwrite_m, o_memtoreg_w, o_regwrite_w;
  logic [RAW-1:0]   o_rd_w;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .OPW     (OPW),
    .RAW     (RAW),
    .ALUFW   (ALUFW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid_d    (i_valid_d),
    .i_opcode_d   (i_opcode_d),
    .i_rs_d       (i_rs_d),
    .i_rt_d       (i_rt_d),
    .i_rd_d       (i_rd_d),
    .i_zero_e     (i_zero_e),
    .o_stall_f    (o_stall_f),
    .o_stall_d    (o_stall_d),
    .o_flush_d    (o_flush_d),
    .o_redirect_e (o_redirect_e),
    .o_alufunc_e  (o_alufunc_e),
    .o_imm_e      (o_imm_e),
    .o_fwd_a_e    (o_fwd_a_e),
    .o_fwd_b_e    (o_fwd_b_e),
    .o_memwrite_m (o_memwrite_m),
    .o_memtoreg_w (o_memtoreg_w),
    .o_regwrite_w (o_regwrite_w),
    .o_rd_w       (o_rd_w)
  );

  // One in-flight instruction; ecyc counts cycles already spent in E.
  typedef struct {
    bit v;
    int op, rd, rs, rt, ecyc;
  } instr_t;

  instr_t st_e, st_m, st_w, bub;
  int  n_checks = 0, n_fail = 0;
  bit  started = 0;
  int  d_v, d_op, d_rd, d_rs, d_rt, d_z, d_r;
  bit  x_redirect, x_hold, x_lu, x_stall;

  function automatic bit writes(instr_t i);
    return i.v && (i.op inside {1, 2, 3, 4, 5, 6, 10}) && i.rd != 0;
  endfunction
  function automatic bit reads_rs(int op);
    return op inside {1, 2, 3, 4, 5, 6, 7, 8, 10};
  endfunction
  function automatic bit reads_rt(int op);
    return op inside {1, 2, 3, 4, 7, 8, 10};
  endfunction
  function automatic int alu_of(instr_t i);
    if (!i.v) return 0;
    case (i.op)
      2, 8:    return 1;
      3:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction
  function automatic int fwd_of(int src);
    if (writes(st_m) && st_m.rd == src) return 2;
    if (writes(st_w) && st_w.rd == src) return 1;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t d_instr();
    instr_t d;
    d = bub;
    if (d_v != 0) begin
      d.v = 1; d.op = d_op; d.rd = d_rd; d.rs = d_rs; d.rt = d_rt;
    end
    return d;
  endfunction

  task automatic compare_all();
    instr_t d;
    d = d_instr();
    x_redirect = st_e.v && (st_e.op == 9 || (st_e.op == 8 && d_z != 0));
    x_hold     = st_e.v && st_e.op == 10 && st_e.ecyc < MUL_LAT - 1;
    x_lu       = st_e.v && st_e.op == 6 && st_e.rd != 0 && d.v &&
                 ((reads_rs(d.op) && d.rs == st_e.rd) || (reads_rt(d.op) && d.rt == st_e.rd));
    x_stall    = x_hold || (x_lu && !x_redirect);
    check("stall_f",    o_stall_f,    x_stall);
    check("stall_d",    o_stall_d,    x_stall);
    check("flush_d",    o_flush_d,    x_redirect);
    check("redirect_e", o_redirect_e, x_redirect);
    check("alufunc_e",  o_alufunc_e,  alu_of(st_e));
    check("imm_e",      o_imm_e,      st_e.v && (st_e.op inside {5, 6, 7}));
    check("fwd_a_e",    o_fwd_a_e,    st_e.v ? fwd_of(st_e.rs) : 0);
    check("fwd_b_e",    o_fwd_b_e,    st_e.v ? fwd_of(st_e.rt) : 0);
    check("memwrite_m", o_memwrite_m, st_m.v && st_m.op == 7);
    check("memtoreg_w", o_memtoreg_w, st_w.v && st_w.op == 6);
    check("regwrite_w", o_regwrite_w, writes(st_w));
    check("rd_w",       o_rd_w,       st_w.v ? st_w.rd : 0);
  endtask

  task automatic model_advance();
    instr_t d;
    d = d_instr();
    if (d_r != 0) begin
      st_e = bub; st_m = bub; st_w = bub;
    end else begin
      st_w = st_m;
      if (x_hold) begin
        st_m = bub;
        st_e.ecyc++;
      end else begin
        st_m = st_e;
        st_e = (x_redirect || x_lu) ? bub : d;
      end
    end
  endtask

  // Presents one D-stage slot for a cycle and checks every output against the model.
  task automatic drive(input int v, input int op, input int rd, input int rs,
                       input int rt, input int z, input int r);
    if (started) begin
      @(posedge clk);
      model_advance();
    end
    @(negedge clk);
    d_v = v; d_op = op; d_rd = rd; d_rs = rs; d_rt = rt; d_z = z; d_r = r;
    reset      = (r != 0);
    i_valid_d  = (v != 0);
    i_opcode_d = OPW'(op);
    i_rd_d     = RAW'(rd);
    i_rs_d     = RAW'(rs);
    i_rt_d     = RAW'(rt);
    i_zero_e   = (z != 0);
    #1;
    compare_all();
    started = 1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_all_zero();
    check("rst_stall_d",  o_stall_d,    0);
    check("rst_stall_f",  o_stall_f,    0);
    check("rst_flush",    o_flush_d,    0);
    check("rst_redirect", o_redirect_e, 0);
    check("rst_imm",      o_imm_e,      0);
    check("rst_fwd_a",    o_fwd_a_e,    0);
    check("rst_fwd_b",    o_fwd_b_e,    0);
    check("rst_regwrite", o_regwrite_w, 0);
    check("rst_rd_w",     o_rd_w,       0);
  endtask

  initial begin
    int v, op, rd, rs, rt;
    bub = '{v: 0, op: 0, rd: 0, rs: 0, rt: 0, ecyc: 0};
    st_e = bub; st_m = bub; st_w = bub;
    reset = 1'b1; i_valid_d = 1'b0; i_opcode_d = '0;
    i_rs_d = '0; i_rt_d = '0; i_rd_d = '0; i_zero_e = 1'b0;

    repeat (2) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), 1);
      expect_all_zero();
    end

    drive(1, 1, 1, 2, 3, 0, 0);                       // ADD r1,r2,r3
    nop();  check("add_alu", o_alufunc_e, 0); check("add_imm", o_imm_e, 0);
    nop();  check("add_w_early", o_regwrite_w, 0);
    nop();  check("add_regwrite_w", o_regwrite_w, 1); check("add_rd_w", o_rd_w, 1);

    drive(1, 6, 2, 1, 0, 0, 0);                       // LD r2
    drive(1, 1, 3, 2, 1, 0, 0);                       // ADD r3,r2,r1
    check("lu_stall_f", o_stall_f, 1); check("lu_stall_d", o_stall_d, 1);
    drive(1, 1, 3, 2, 1, 0, 0);
    check("lu_stall_once", o_stall_d, 0);
    drive(1, 1, 4, 1, 2, 0, 0);                       // ADD r4,r1,r2
    check("lu_fwd_a_w", o_fwd_a_e, 1); check("lu_fwd_b", o_fwd_b_e, 0);
    drive(1, 2, 5, 4, 4, 0, 0);                       // SUB r5,r4,r4
    nop();
    check("sub_fwd_a_m", o_fwd_a_e, 2); check("sub_fwd_b_m", o_fwd_b_e, 2);
    check("sub_alu", o_alufunc_e, 1);
    drive(1, 1, 0, 1, 2, 0, 0);                       // ADD r0,r1,r2
    drive(1, 2, 5, 0, 0, 0, 0);                       // SUB r5,r0,r0
    nop();  check("r0_fwd_a", o_fwd_a_e, 0); check("r0_fwd_b", o_fwd_b_e, 0);
    nop();  check("r0_regwrite_w", o_regwrite_w, 0);

    drive(1, 8, 0, 1, 2, 0, 0);                       // BEQ taken
    drive(1, 5, 3, 1, 0, 1, 0);
    check("beq_redirect", o_redirect_e, 1); check("beq_flush", o_flush_d, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    check("beq_bubble_imm", o_imm_e, 0); check("beq_bubble_redir", o_redirect_e, 0);
    drive(1, 8, 0, 1, 2, 0, 0);                       // BEQ not taken
    drive(1, 5, 3, 1, 0, 0, 0);
    check("beqnt_redirect", o_redirect_e, 0); check("beqnt_flush", o_flush_d, 0);
    nop();  check("beqnt_addi_imm", o_imm_e, 1);
    drive(1, 9, 0, 0, 0, 0, 0);                       // JMP
    drive(1, 5, 3, 1, 0, 0, 0);
    check("jmp_redirect", o_redirect_e, 1); check("jmp_flush", o_flush_d, 1);
    nop();  check("jmp_bubble_imm", o_imm_e, 0);

    drive(1, 10, 6, 1, 2, 0, 0);                      // MUL r6
    nop();  check("mul_stall1", o_stall_d, 1); check("mul_stall1_f", o_stall_f, 1);
    nop();  check("mul_stall2", o_stall_d, 1);
    nop();  check("mul_release", o_stall_d, 0); check("mul_w_early", o_regwrite_w, 0);
    nop();  check("mul_w_late1", o_regwrite_w, 0);
    nop();  check("mul_regwrite_w", o_regwrite_w, 1); check("mul_rd_w", o_rd_w, 6);

    drive(1, 10, 5, 1, 2, 0, 0);                      // MUL r5, aborted by reset
    nop();  check("mulr_stall1", o_stall_d, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check("mulr_stall2", o_stall_d, 1);
    nop();  check("mulr_abort", o_stall_d, 0); check("mulr_abort_f", o_stall_f, 0);
    repeat (3) begin
      nop(); check("mulr_no_wb", o_regwrite_w, 0);
    end

    drive(1, 6, 1, 0, 0, 0, 0);                       // LD r1
    drive(1, 8, 0, 1, 1, 0, 0);                       // BEQ r1,r1 waits on the load
    check("ldbeq_stall", o_stall_d, 1); check("ldbeq_noflush", o_flush_d, 0);
    drive(1, 8, 0, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 1, 1, 0);
    check("redir_flush", o_flush_d, 1); check("redir_nostall", o_stall_d, 0);
    nop();

    v = 0; op = 0; rd = 0; rs = 0; rt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!x_stall) begin
        v  = ($urandom_range(0, 99) < 85) ? 1 : 0;
        op = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 10) : $urandom_range(11, 15);
        rd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
        rs = $urandom_range(0, 3);
        rt = $urandom_range(0, 3);
      end
      drive(v, op, rd, rs, rt, $urandom_range(0, 1), ($urandom_range(0, 99) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
